// File: rtl/sprite_renderer_ext.sv
// rtl/sprite_renderer_ext.sv - parametrised single-colour sprite renderer with flip, scaling and mirrored ROM
//
// Draws one sprite line per load/hstart handshake from a row-addressed bitmap ROM.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   enable            - vstart accepted only while high (checked in IDLE)
//   vstart            - sprite top row reached; starts a sprite when idle
//   load              - safe to fetch the next ROM row
//   hstart            - sprite left column reached; starts drawing a fetched line
//   hflip, vflip      - flip controls, latched on an accepted vstart
//   rom_addr          - registered ROM row address
//   rom_bits          - ROM row data (combinational ROM)
//   gfx               - registered pixel output
//   in_progress       - high whenever the renderer is not idle
//   done              - one-cycle pulse after the last pixel of the sprite
module sprite_renderer_ext #(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int MIRROR     = 1,
  parameter int SCALE_LOG2 = 0,
  localparam int ROM_DW    = (MIRROR != 0) ? SPR_W / 2 : SPR_W,
  localparam int YW        = $clog2(SPR_H),
  localparam int XW        = $clog2(SPR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              vstart,
  input  logic              load,
  input  logic              hstart,
  input  logic              hflip,
  input  logic              vflip,
  output logic [YW-1:0]     rom_addr,
  input  logic [ROM_DW-1:0] rom_bits,
  output logic              gfx,
  output logic              in_progress,
  output logic              done
);

  // Sub-pixel counters need at least one bit even when no scaling is used.
  localparam int SW = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'((1 << SCALE_LOG2) - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LOAD,
    S_LOAD_SETUP,
    S_LOAD_FETCH,
    S_WAIT_HSTART,
    S_DRAW
  } state_t;

  state_t            state_q, state_d;
  logic [YW-1:0]     ycount_q, ycount_d;
  logic [XW-1:0]     xcount_q, xcount_d;
  logic [SW-1:0]     ysub_q, ysub_d;
  logic [SW-1:0]     xsub_q, xsub_d;
  logic              hflip_q, hflip_d;
  logic              vflip_q, vflip_d;
  logic [ROM_DW-1:0] rowbits_q, rowbits_d;
  logic [YW-1:0]     rom_addr_q, rom_addr_d;
  logic              gfx_q, gfx_d;
  logic              done_q, done_d;

  logic              xsub_wrap, ysub_wrap, line_end;
  logic [XW-1:0]     col, mcol, idx;
  logic [SPR_W-1:0]  row_ext;

  assign xsub_wrap = (xsub_q == SUB_MAX);
  assign ysub_wrap = (ysub_q == SUB_MAX);
  assign line_end  = (xcount_q == XW'(SPR_W - 1)) && xsub_wrap;

  // Widths are powers of two, so W-1-x is just the bitwise complement.
  // In mirrored format the right half folds back onto the stored left half.
  assign col     = hflip_q ? ~xcount_q : xcount_q;
  assign mcol    = col[XW-1] ? ~col : col;
  assign idx     = (MIRROR != 0) ? mcol : col;
  assign row_ext = SPR_W'(rowbits_q);

  always_comb begin
    state_d    = state_q;
    ycount_d   = ycount_q;
    xcount_d   = xcount_q;
    ysub_d     = ysub_q;
    xsub_d     = xsub_q;
    hflip_d    = hflip_q;
    vflip_d    = vflip_q;
    rowbits_d  = rowbits_q;
    rom_addr_d = rom_addr_q;
    gfx_d      = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        ycount_d = '0;
        ysub_d   = '0;
        if (enable && vstart) begin
          hflip_d = hflip;
          vflip_d = vflip;
          state_d = S_WAIT_LOAD;
        end
      end
      S_WAIT_LOAD: begin
        xcount_d = '0;
        xsub_d   = '0;
        if (load) state_d = S_LOAD_SETUP;
      end
      S_LOAD_SETUP: begin
        rom_addr_d = vflip_q ? ~ycount_q : ycount_q;
        state_d    = S_LOAD_FETCH;
      end
      S_LOAD_FETCH: begin
        rowbits_d = rom_bits;
        state_d   = S_WAIT_HSTART;
      end
      S_WAIT_HSTART: begin
        if (hstart) state_d = S_DRAW;
      end
      S_DRAW: begin
        gfx_d  = row_ext[idx];
        xsub_d = xsub_wrap ? '0 : xsub_q + 1'b1;
        if (xsub_wrap) xcount_d = xcount_q + 1'b1;
        if (line_end) begin
          ysub_d = ysub_wrap ? '0 : ysub_q + 1'b1;
          if (ysub_wrap) ycount_d = ycount_q + 1'b1;
          if (ysub_wrap && (ycount_q == YW'(SPR_H - 1))) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WAIT_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ycount_q   <= '0;
      xcount_q   <= '0;
      ysub_q     <= '0;
      xsub_q     <= '0;
      hflip_q    <= 1'b0;
      vflip_q    <= 1'b0;
      rowbits_q  <= '0;
      rom_addr_q <= '0;
      gfx_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ycount_q   <= ycount_d;
      xcount_q   <= xcount_d;
      ysub_q     <= ysub_d;
      xsub_q     <= xsub_d;
      hflip_q    <= hflip_d;
      vflip_q    <= vflip_d;
      rowbits_q  <= rowbits_d;
      rom_addr_q <= rom_addr_d;
      gfx_q      <= gfx_d;
      done_q     <= done_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign gfx         = gfx_q;
  assign done        = done_q;
  assign in_progress = (state_q != S_IDLE);

endmodule

// File: tb/tb_sprite_renderer_ext.sv
// tb/tb_sprite_renderer_ext.sv - directed bench for sprite_renderer_ext
module tb_sprite_renderer_ext;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, vstart, load, hstart, hflip, vflip;
  logic [2:0] en;

  logic [3:0] a0, a1;
  logic [1:0] a2;
  logic [7:0] rb0, rb1, rb2;
  logic       g0, g1, g2, ip0, ip1, ip2, d0, d1, d2;

  // ROM images: instance 0 has rows 0 and 5 = 8'h01, instance 1 row 0 only,
  // instance 2 (8 wide, unmirrored) holds 8'b0000_0011 in every row.
  assign rb0 = ((a0 == 4'd0) || (a0 == 4'd5)) ? 8'h01 : 8'h00;
  assign rb1 = (a1 == 4'd0) ? 8'h01 : 8'h00;
  assign rb2 = 8'h03;

  sprite_renderer_ext u0 (
    .clk(clk), .reset(reset), .enable(en[0]), .vstart(vstart), .load(load),
    .hstart(hstart), .hflip(hflip), .vflip(vflip), .rom_addr(a0),
    .rom_bits(rb0), .gfx(g0), .in_progress(ip0), .done(d0)
  );

  sprite_renderer_ext #(.SCALE_LOG2(1)) u1 (
    .clk(clk), .reset(reset), .enable(en[1]), .vstart(vstart), .load(load),
    .hstart(hstart), .hflip(hflip), .vflip(vflip), .rom_addr(a1),
    .rom_bits(rb1), .gfx(g1), .in_progress(ip1), .done(d1)
  );

  sprite_renderer_ext #(.SPR_W(8), .SPR_H(4), .MIRROR(0)) u2 (
    .clk(clk), .reset(reset), .enable(en[2]), .vstart(vstart), .load(load),
    .hstart(hstart), .hflip(hflip), .vflip(vflip), .rom_addr(a2),
    .rom_bits(rb2), .gfx(g2), .in_progress(ip2), .done(d2)
  );

  int   sel;
  logic gfx_s, ip_s, done_s;
  int   addr_s;

  always_comb begin
    gfx_s = g0; ip_s = ip0; done_s = d0; addr_s = int'(a0);
    case (sel)
      1: begin gfx_s = g1; ip_s = ip1; done_s = d1; addr_s = int'(a1); end
      2: begin gfx_s = g2; ip_s = ip2; done_s = d2; addr_s = int'(a2); end
      default: ;
    endcase
  end

  int n_chk = 0, n_pass = 0;
  int dn, dn_mid, gh, iph;
  logic [63:0] pxs [64];
  int          ads [64];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (done_s) dn++;
    if (gfx_s) gh++;
    if (ip_s) iph++;
  endtask

  // One load/hstart handshake; samples npix pixels starting at hstart+2.
  // early=1 raises hstart during LOAD_FETCH instead of WAIT_HSTART.
  task automatic run_line(input int npix, input bit early,
                          output logic [63:0] px, output int addr);
    px = '0;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    addr = addr_s;
    if (early) hstart = 1'b1;
    tick();
    hstart = !early;
    tick();
    hstart = 1'b0;
    for (int p = 0; p < npix; p++) begin
      tick();
      px[p] = gfx_s;
    end
  endtask

  task automatic start_sprite();
    vstart = 1'b1;
    tick();
    vstart = 1'b0;
  endtask

  task automatic run_sprite(input int nl, input int len, input int vline, input bit toggle);
    logic [63:0] px;
    int          a;
    dn = 0;
    dn_mid = -1;
    start_sprite();
    for (int i = 0; i < nl; i++) begin
      if (i == vline) begin
        vstart = 1'b1;
        tick();
        vstart = 1'b0;
      end
      if (toggle) hflip = ~hflip;
      run_line(len, 1'b0, px, a);
      pxs[i] = px;
      ads[i] = a;
      if (i == nl - 2) dn_mid = dn;
    end
  endtask

  initial begin
    int          bad, badpx;
    logic [63:0] px;
    int          a;

    reset = 1'b1; vstart = 1'b0; load = 1'b0; hstart = 1'b0;
    hflip = 1'b0; vflip = 1'b0; en = 3'b000; sel = 0;
    dn = 0; gh = 0; iph = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_gfx", {61'd0, g2, g1, g0}, 64'd0);
    check("rst_inprog", {61'd0, ip2, ip1, ip0}, 64'd0);
    check("rst_done", {61'd0, d2, d1, d0}, 64'd0);
    check("rst_addr0", 64'(a0), 64'd0);

    // 1: defaults, mirrored row 8'h01 -> pixels 0 and 15
    sel = 0; en = 3'b001;
    run_sprite(16, 16, -1, 1'b0);
    bad = 0; badpx = 0;
    for (int i = 0; i < 16; i++) begin
      if (ads[i] != i) bad++;
      if (pxs[i] != (((i == 0) || (i == 5)) ? 64'h8001 : 64'h0)) badpx++;
    end
    check("t1_line0", pxs[0], 64'h8001);
    check("t1_addr_bad", 64'(bad), 64'd0);
    check("t1_px_bad", 64'(badpx), 64'd0);
    check("t1_done_mid", 64'(dn_mid), 64'd0);
    check("t1_done", 64'(dn), 64'd1);
    tick();
    check("t1_gfx_after", {63'd0, gfx_s}, 64'd0);
    check("t1_inprog_after", {63'd0, ip_s}, 64'd0);

    // 2: x2 scaling, 32-cycle lines, each row fetched twice
    sel = 1; en = 3'b010;
    run_sprite(32, 32, -1, 1'b0);
    bad = 0; badpx = 0;
    for (int i = 0; i < 32; i++) begin
      if (ads[i] != i / 2) bad++;
      if (pxs[i] != ((i < 2) ? 64'hC000_0003 : 64'h0)) badpx++;
    end
    check("t2_line0", pxs[0], 64'hC000_0003);
    check("t2_line1", pxs[1], 64'hC000_0003);
    check("t2_addr_bad", 64'(bad), 64'd0);
    check("t2_px_bad", 64'(badpx), 64'd0);
    check("t2_done_mid", 64'(dn_mid), 64'd0);
    check("t2_done", 64'(dn), 64'd1);

    // 3: unmirrored 8-wide, hflip latched at vstart, toggled mid-sprite
    sel = 2; en = 3'b100; hflip = 1'b1;
    run_sprite(4, 8, -1, 1'b1);
    badpx = 0;
    for (int i = 0; i < 4; i++) if (pxs[i] != 64'hC0) badpx++;
    check("t3_line0_flip", pxs[0], 64'hC0);
    check("t3_px_bad", 64'(badpx), 64'd0);
    check("t3_done", 64'(dn), 64'd1);
    hflip = 1'b0;
    run_sprite(4, 8, -1, 1'b0);
    check("t3_line0_noflip", pxs[0], 64'h03);
    check("t3_addr3", 64'(ads[3]), 64'd3);

    // 4: vflip reverses row order; extra vstart at line 5 ignored
    sel = 0; en = 3'b001; vflip = 1'b1;
    run_sprite(16, 16, 5, 1'b0);
    vflip = 1'b0;
    bad = 0; badpx = 0;
    for (int i = 0; i < 16; i++) begin
      if (ads[i] != 15 - i) bad++;
      if (pxs[i] != (((i == 15) || (i == 10)) ? 64'h8001 : 64'h0)) badpx++;
    end
    check("t4_addr0", 64'(ads[0]), 64'd15);
    check("t4_addr_bad", 64'(bad), 64'd0);
    check("t4_px_bad", 64'(badpx), 64'd0);
    check("t4_done", 64'(dn), 64'd1);

    // 5: reset while drawing row 5 (pixel 0 of row 5 is lit)
    dn = 0;
    start_sprite();
    for (int i = 0; i < 5; i++) run_line(16, 1'b0, px, a);
    run_line(1, 1'b0, px, a);
    check("t5_row5_addr", 64'(a), 64'd5);
    check("t5_row5_px0", px, 64'd1);
    reset = 1'b1;
    tick();
    check("t5_rst_gfx", {63'd0, gfx_s}, 64'd0);
    check("t5_rst_inprog", {63'd0, ip_s}, 64'd0);
    check("t5_rst_addr", 64'(addr_s), 64'd0);
    reset = 1'b0;
    tick();
    run_sprite(16, 16, -1, 1'b0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (ads[i] != i) bad++;
    check("t5_addr_bad", 64'(bad), 64'd0);
    check("t5_line0", pxs[0], 64'h8001);
    check("t5_done", 64'(dn), 64'd1);

    // 6: disabled vstart ignored; early hstart skips a line
    en = 3'b000; gh = 0; iph = 0;
    for (int k = 0; k < 3; k++) begin
      start_sprite();
      run_line(20, 1'b0, px, a);
    end
    check("t6_dis_inprog", 64'(iph), 64'd0);
    check("t6_dis_gfx", 64'(gh), 64'd0);
    en = 3'b001; dn = 0;
    start_sprite();
    run_line(16, 1'b1, px, a);
    check("t6_early_px", px, 64'd0);
    check("t6_early_inprog", {63'd0, ip_s}, 64'd1);
    run_line(16, 1'b0, px, a);
    check("t6_next_px", px, 64'h8001);
    check("t6_next_addr", 64'(a), 64'd0);
    for (int i = 1; i < 16; i++) run_line(16, 1'b0, px, a);
    check("t6_done", 64'(dn), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
